// File: rtl/vehicle_pwm_pkg.sv
// Shared definitions for the vehicle PWM blocks (modulator and demodulator).
//   PWM_RESOLUTION : default pulse-width resolution shared by both ends of the link
//   PWM_TIMEOUT    : default number of cycles without a rising edge before the line is lost
//   pwm_demod_state_t : demodulator FSM state
//   idle_cnt_width()  : width of a counter that must be able to hold TIMEOUT
package vehicle_pwm_pkg;

    localparam int PWM_RESOLUTION = 4;
    localparam int PWM_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_demod_state_t;

    function automatic int idle_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pulse_width_demodulator_if.sv
// Bundle between a PWM line source and the demodulator.
//   pulse       : PWM line, asynchronous to the demodulator clock
//   pulse_width : measured high time in cycles (saturating)
//   period      : measured rising-edge-to-rising-edge period in cycles (saturating)
//   valid       : one-cycle strobe when pulse_width/period update
//   signal_lost : high while no valid period is being received
// master = side driving the line and consuming measurements, slave = demodulator.
interface pulse_width_demodulator_if
    import vehicle_pwm_pkg::*;
#(
    parameter int RESOLUTION = PWM_RESOLUTION
);

    logic                  pulse;
    logic [RESOLUTION-1:0] pulse_width;
    logic [RESOLUTION:0]   period;
    logic                  valid;
    logic                  signal_lost;

    modport master (
        output pulse,
        input  pulse_width,
        input  period,
        input  valid,
        input  signal_lost
    );

    modport slave (
        input  pulse,
        output pulse_width,
        output period,
        output valid,
        output signal_lost
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input followed by one delay flop
// for edge detection. Reusable for any slow asynchronous vehicle input.
//   clk, reset : clock and synchronous active-high reset (clears all flops)
//   async_in   : asynchronous input
//   level      : synchronized level (second synchronizer flop)
//   rise       : one-cycle pulse on a synchronized 0->1 transition
//   fall       : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;   // metastability catcher
    logic sync_p1;   // first safe copy of the input
    logic sync_p2;   // previous safe value, for edge detection

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            // p0 -> p1: resolve metastability
            sync_p0 <= async_in;
            sync_p1 <= sync_p0;
            // p1 -> p2: one-cycle history
            sync_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~sync_p2;
    assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/pulse_width_demodulator.sv
// Measures high time and period of an asynchronous PWM line in clk cycles.
// One measurement is published per complete rising-edge-to-rising-edge period;
// a line that stops toggling for TIMEOUT cycles is reported once as lost, with
// pulse_width showing whether it is stuck high (all ones) or stuck low (zero).
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of pulse_width_demodulator_if
//                (pulse in; pulse_width, period, valid, signal_lost out)
// Parameters: RESOLUTION (pulse_width width), TIMEOUT (> 2^(RESOLUTION+1)).
module pulse_width_demodulator
    import vehicle_pwm_pkg::*;
#(
    parameter int RESOLUTION = PWM_RESOLUTION,
    parameter int TIMEOUT    = PWM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    pulse_width_demodulator_if.slave bus
);

    localparam int IDLE_W = idle_cnt_width(TIMEOUT);
    localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(TIMEOUT);

    function automatic logic [RESOLUTION-1:0] sat_inc_high(input logic [RESOLUTION-1:0] v);
        return (&v) ? v : v + RESOLUTION'(1);
    endfunction

    function automatic logic [RESOLUTION:0] sat_inc_period(input logic [RESOLUTION:0] v);
        return (&v) ? v : v + (RESOLUTION+1)'(1);
    endfunction

    function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
        return (&v) ? v : v + IDLE_W'(1);
    endfunction

    logic level;
    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.pulse),
        .level    (level),
        .rise     (rise),
        .fall     (fall)
    );

    pwm_demod_state_t state;
    pwm_demod_state_t state_n;

    logic [RESOLUTION-1:0] high_cnt;
    logic [RESOLUTION:0]   period_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    logic [RESOLUTION-1:0] pulse_width_q;
    logic [RESOLUTION:0]   period_q;
    logic                  valid_q;
    logic                  signal_lost_q;

    logic restart;
    logic publish;
    logic timeout;
    logic count;
    logic count_high;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A rise always takes priority over the timeout in the same cycle, so a
    // period ending exactly at the timeout boundary is still measured.
    // The cycle that sees the fall is not added to high_cnt; together with the
    // restart value of 1 this makes the high time equal to the number of
    // synchronized high cycles.
    always_comb begin
        state_n    = state;
        restart    = 1'b0;
        publish    = 1'b0;
        timeout    = 1'b0;
        count      = 1'b0;
        count_high = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    restart = 1'b1;
                    state_n = HIGH;
                end
            end
            HIGH, LOW: begin
                if (rise) begin
                    publish = 1'b1;
                    restart = 1'b1;
                    state_n = HIGH;
                end else if (idle_cnt >= TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end else begin
                    count = 1'b1;
                    if (state == HIGH) begin
                        count_high = ~fall;
                        if (fall) begin
                            state_n = LOW;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            high_cnt      <= '0;
            period_cnt    <= '0;
            idle_cnt      <= '0;
            pulse_width_q <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            signal_lost_q <= 1'b1;
        end else begin
            // counter stage
            if (restart) begin
                high_cnt   <= RESOLUTION'(1);
                period_cnt <= (RESOLUTION+1)'(1);
                idle_cnt   <= IDLE_W'(1);
            end else if (count) begin
                period_cnt <= sat_inc_period(period_cnt);
                idle_cnt   <= sat_inc_idle(idle_cnt);
                if (count_high) begin
                    high_cnt <= sat_inc_high(high_cnt);
                end
            end

            // output stage: hold between strobes
            valid_q <= publish | timeout;
            if (publish) begin
                pulse_width_q <= high_cnt;
                period_q      <= period_cnt;
                signal_lost_q <= 1'b0;
            end else if (timeout) begin
                pulse_width_q <= level ? '1 : '0;
                period_q      <= '0;
                signal_lost_q <= 1'b1;
            end
        end
    end

    assign bus.pulse_width = pulse_width_q;
    assign bus.period      = period_q;
    assign bus.valid       = valid_q;
    assign bus.signal_lost = signal_lost_q;

endmodule

// File: tb/tb_pulse_width_demodulator.sv
// Bench for pulse_width_demodulator: directed scenarios plus random line
// activity, checked every cycle against an edge-timestamp reference model.
module tb_pulse_width_demodulator;
    import vehicle_pwm_pkg::*;

    localparam int RES     = 4;
    localparam int TMO     = 64;
    localparam int PW_MAX  = 15;
    localparam int PER_MAX = 31;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pulse_width_demodulator_if #(.RESOLUTION(RES)) bus ();

    pulse_width_demodulator #(
        .RESOLUTION (RES),
        .TIMEOUT    (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests   = 0;
    int fails   = 0;
    int edge_n  = 0;
    int strobes = 0;

    // Reference model: the measured line is the raw line delayed two edges;
    // everything is derived from edge numbers of rises and falls.
    bit h0, h1, h2, h3;      // raw samples at edges n, n-1, n-2, n-3
    bit active;              // a rise has been seen and no timeout since
    int rise_e, fall_e, deadline;
    bit exp_valid;
    int exp_pw, exp_per;
    bit exp_lost;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @edge %0d: observed %0b expected %0b", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input bit rst);
        exp_valid = 1'b0;
        if (rst) begin
            h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            active   = 1'b0;
            exp_pw   = 0;
            exp_per  = 0;
            exp_lost = 1'b1;
        end else begin
            h3 = h2; h2 = h1; h1 = h0; h0 = v;
            if (h2 && !h3) begin
                if (active) begin
                    exp_valid = 1'b1;
                    exp_pw    = (fall_e - rise_e > PW_MAX) ? PW_MAX : fall_e - rise_e;
                    exp_per   = (edge_n - rise_e > PER_MAX) ? PER_MAX : edge_n - rise_e;
                    exp_lost  = 1'b0;
                end
                active   = 1'b1;
                rise_e   = edge_n;
                deadline = edge_n + TMO;
            end else if (active && edge_n == deadline) begin
                exp_valid = 1'b1;
                exp_pw    = h2 ? PW_MAX : 0;
                exp_per   = 0;
                exp_lost  = 1'b1;
                active    = 1'b0;
            end
            if (!h2 && h3) begin
                fall_e = edge_n;
            end
        end
    endtask

    task automatic tick();
        bit v;
        bit rst;
        v   = bus.pulse;
        rst = reset;
        @(posedge clk);
        #1;
        edge_n++;
        model_edge(v, rst);
        if (bus.valid === 1'b1) strobes++;
        check_bit("valid", bus.valid, exp_valid);
        check_int("pulse_width", 32'(bus.pulse_width), 32'(exp_pw));
        check_int("period", 32'(bus.period), 32'(exp_per));
        check_bit("signal_lost", bus.signal_lost, exp_lost);
    endtask

    task automatic hold(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            bus.pulse = lvl;
            tick();
        end
    endtask

    task automatic hand_period(input int hi, input int lo);
        hold(1'b1, hi);
        hold(1'b0, lo);
    endtask

    // Equivalent of the modulator at RESOLUTION = 4: 16-cycle frames, high for ctrl cycles.
    task automatic pwm_frames(input int ctrl, input int n);
        for (int f = 0; f < n; f++) begin
            for (int i = 0; i < 16; i++) begin
                bus.pulse = (i < ctrl);
                tick();
            end
        end
    endtask

    task automatic expect_now(input string tag, input int pw, input int per, input bit lost);
        check_int({tag, ".pulse_width"}, 32'(bus.pulse_width), 32'(pw));
        check_int({tag, ".period"}, 32'(bus.period), 32'(per));
        check_bit({tag, ".signal_lost"}, bus.signal_lost, lost);
    endtask

    initial begin
        int s0;
        reset     = 1'b1;
        bus.pulse = 1'b0;
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
        active = 1'b0; rise_e = 0; fall_e = 0; deadline = 0;
        exp_valid = 1'b0; exp_pw = 0; exp_per = 0; exp_lost = 1'b1;

        // reset for 10 cycles
        for (int i = 0; i < 10; i++) tick();
        expect_now("reset_state", 0, 0, 1'b1);
        reset = 1'b0;

        // lock onto ctrl = 3; the first period must not strobe
        s0 = strobes;
        pwm_frames(3, 1);
        check_int("first_period_strobes", 32'(strobes - s0), 32'd0);
        pwm_frames(3, 5);
        check_int("ctrl3_strobes", 32'(strobes - s0), 32'd5);
        expect_now("ctrl3", 3, 16, 1'b0);

        // ctrl change 3 -> 10
        pwm_frames(10, 4);
        expect_now("ctrl10", 10, 16, 1'b0);

        // line stuck low: one loss strobe, then silence
        s0 = strobes;
        pwm_frames(0, 6);
        check_int("stuck_low_strobes", 32'(strobes - s0), 32'd1);
        expect_now("stuck_low", 0, 0, 1'b1);

        // relock, then line stuck high, then relock by hand
        pwm_frames(5, 3);
        expect_now("relock5", 5, 16, 1'b0);
        hold(1'b1, 100);
        expect_now("stuck_high", PW_MAX, 0, 1'b1);
        hold(1'b0, 5);
        hand_period(8, 8);
        hand_period(8, 8);
        expect_now("relock_hand", 8, 16, 1'b0);

        // saturation of high time and period
        for (int i = 0; i < 3; i++) hand_period(20, 10);
        expect_now("sat_pw", PW_MAX, 30, 1'b0);
        for (int i = 0; i < 3; i++) hand_period(20, 20);
        expect_now("sat_period", PW_MAX, PER_MAX, 1'b0);

        // reset pulsed while the FSM is in HIGH
        hand_period(6, 10);
        hand_period(6, 10);
        hold(1'b1, 6);
        hold(1'b0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_now("mid_reset", 0, 0, 1'b1);
        check_bit("mid_reset.valid", bus.valid, 1'b0);
        s0 = strobes;
        hold(1'b0, 10);
        hand_period(6, 10);
        check_int("post_reset_first_strobes", 32'(strobes - s0), 32'd0);
        hand_period(6, 10);
        check_int("post_reset_second_strobes", 32'(strobes - s0), 32'd1);
        expect_now("post_reset", 6, 16, 1'b0);

        // random line activity
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 4))
                0, 1: hand_period(int'($urandom_range(1, 24)), int'($urandom_range(1, 24)));
                2:    pwm_frames(int'($urandom_range(0, 15)), 2);
                3:    hold(1'b0, int'($urandom_range(40, 90)));
                default: hold(1'b1, int'($urandom_range(40, 90)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
